// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event generator: event kind encoding,
// per-button state enum and default hold/repeat timing.
package btn_event_pkg;

  localparam logic [1:0] KIND_PRESS   = 2'd0;
  localparam logic [1:0] KIND_REPEAT  = 2'd1;
  localparam logic [1:0] KIND_RELEASE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT,
    ST_HELD
  } btn_state_e;

  localparam int DEFAULT_DELAY_CYC  = 25_000_000;
  localparam int DEFAULT_REPEAT_CYC = 10_000_000;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_fifo.sv
// Show-ahead synchronous FIFO for button events; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module btn_event_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/btn_event_gen.sv
// Turns debounced button levels into PRESS/REPEAT/RELEASE events on a
// valid/ready stream. Define BTN_AUTO_REPEAT_EN to build the auto-repeat timers.
module btn_event_gen
  import btn_event_pkg::*;
#(
  parameter int N_BTN      = 5,
  parameter int DELAY_CYC  = DEFAULT_DELAY_CYC,
  parameter int REPEAT_CYC = DEFAULT_REPEAT_CYC,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BTN-1:0]         db_in,
  input  logic                     drop_clr,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_idx,
  output logic [1:0]               evt_kind,
  output logic                     drop_flag
);

  localparam int IDX_W = $clog2(N_BTN);
  localparam int EVT_W = IDX_W + 2;

  if (N_BTN < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      DELAY_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_cfg
    $error("btn_event_gen: invalid parameter set");
  end

  logic [N_BTN-1:0] prev_q, rise, fall;
  btn_state_e       state_q [N_BTN];
  btn_state_e       state_d [N_BTN];
  logic [N_BTN-1:0] set_evt, set_rpt, set_rel;
  logic [N_BTN-1:0] pend_evt_q, pend_evt_d, pend_rpt_q, pend_rpt_d, pend_rel_q, pend_rel_d;
  logic [N_BTN-1:0] grant_evt, grant_rel;
  logic             drop_flag_q, drop_flag_d, drop_set;
  logic             any_pend, push_go, pop, fifo_full, fifo_empty;
  logic [IDX_W-1:0] sel_idx;
  logic [1:0]       sel_kind;
  logic [EVT_W-1:0] head;

  assign rise = db_in & ~prev_q;
  assign fall = ~db_in & prev_q;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int CNT_W = $clog2(max_of(DELAY_CYC, REPEAT_CYC));
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  // A fall always wins; the counter restarts on each state entry and REPEAT.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      set_evt[i] = 1'b0;
      set_rpt[i] = 1'b0;
      set_rel[i] = 1'b0;
      if (fall[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
        set_rel[i] = 1'b1;
      end else begin
        case (state_q[i])
          ST_IDLE: if (rise[i]) begin
            state_d[i] = ST_DELAY;
            cnt_d[i]   = '0;
            set_evt[i] = 1'b1;
          end
          ST_DELAY: begin
            if (cnt_q[i] == DELAY_LAST) begin
              state_d[i] = ST_REPEAT;
              cnt_d[i]   = '0;
              set_evt[i] = 1'b1;
              set_rpt[i] = 1'b1;
            end else if (cnt_q[i] != CNT_MAX) begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (cnt_q[i] == REPEAT_LAST) begin
              cnt_d[i]   = '0;
              set_evt[i] = 1'b1;
              set_rpt[i] = 1'b1;
            end else if (cnt_q[i] != CNT_MAX) begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      set_evt[i] = 1'b0;
      set_rpt[i] = 1'b0;
      set_rel[i] = 1'b0;
      if (fall[i]) begin
        state_d[i] = ST_IDLE;
        set_rel[i] = 1'b1;
      end else if (state_q[i] == ST_IDLE && rise[i]) begin
        state_d[i] = ST_HELD;
        set_evt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BTN; i++) state_q[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < N_BTN; i++) state_q[i] <= state_d[i];
    end
  end
`endif

  // Scanning downward lets the lowest pending button win the last assignment.
  always_comb begin
    any_pend  = 1'b0;
    sel_idx   = '0;
    sel_kind  = KIND_PRESS;
    grant_evt = '0;
    grant_rel = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend_evt_q[i] || pend_rel_q[i]) begin
        any_pend     = 1'b1;
        sel_idx      = IDX_W'(i);
        grant_evt    = '0;
        grant_rel    = '0;
        grant_evt[i] = pend_evt_q[i];
        grant_rel[i] = !pend_evt_q[i];
        sel_kind     = !pend_evt_q[i] ? KIND_RELEASE :
                       (pend_rpt_q[i] ? KIND_REPEAT : KIND_PRESS);
      end
    end
  end

  assign pop     = evt_valid && evt_ready;
  assign push_go = any_pend && (!fifo_full || pop);

  // A new event into a slot being pushed this cycle replaces it without loss.
  always_comb begin
    pend_evt_d = pend_evt_q;
    pend_rpt_d = pend_rpt_q;
    pend_rel_d = pend_rel_q;
    drop_set   = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (push_go && grant_evt[i]) pend_evt_d[i] = 1'b0;
      if (push_go && grant_rel[i]) pend_rel_d[i] = 1'b0;
      if (set_evt[i]) begin
        if (pend_evt_q[i] && !(push_go && grant_evt[i])) begin
          drop_set = 1'b1;
        end else begin
          pend_evt_d[i] = 1'b1;
          pend_rpt_d[i] = set_rpt[i];
        end
      end
      if (set_rel[i]) begin
        if (pend_rel_q[i] && !(push_go && grant_rel[i])) drop_set = 1'b1;
        else pend_rel_d[i] = 1'b1;
      end
    end
    drop_flag_d = drop_set ? 1'b1 : (drop_clr ? 1'b0 : drop_flag_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= '0;
      pend_evt_q  <= '0;
      pend_rpt_q  <= '0;
      pend_rel_q  <= '0;
      drop_flag_q <= 1'b0;
    end else begin
      prev_q      <= db_in;
      pend_evt_q  <= pend_evt_d;
      pend_rpt_q  <= pend_rpt_d;
      pend_rel_q  <= pend_rel_d;
      drop_flag_q <= drop_flag_d;
    end
  end

  btn_event_fifo #(
    .WIDTH(EVT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push_go),
    .push_data_i({sel_idx, sel_kind}),
    .pop_i      (pop),
    .pop_data_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_idx   = evt_valid ? head[EVT_W-1:2] : '0;
  assign evt_kind  = evt_valid ? head[1:0] : 2'd0;
  assign drop_flag = drop_flag_q;

endmodule
